// File: rtl/utim64_irq_arbiter.sv
// Round-robin interrupt arbiter for the four utim64 comparator lines, with valid/ack CPU handshake.
// Define UTIM64_IRQ_ARBITER_SYNC_EN to insert a two-flop synchronizer on iTIMER_IRQ.
module utim64_irq_arbiter (
  input  logic       iCLOCK,
  input  logic       inRESET,
  input  logic [3:0] iTIMER_IRQ,
  input  logic       iMASK_WRITE,
  input  logic [3:0] iMASK_DATA,
  input  logic [3:0] iOVF_CLEAR,
  output logic [3:0] oMASK,
  output logic [3:0] oPENDING,
  output logic [3:0] oOVERFLOW,
  output logic       oIRQ_VALID,
  output logic [1:0] oIRQ_NUM,
  input  logic       iIRQ_ACK
);

  localparam int unsigned IRQ_W = 4;
  localparam int unsigned NUM_W = 2;

  typedef enum logic [0:0] {IDLE, REQ} state_e;

  state_e             state_q, state_d;
  logic [IRQ_W-1:0]   irq_s;
  logic [IRQ_W-1:0]   irq_d_q;
  logic [IRQ_W-1:0]   mask_q, mask_d;
  logic [IRQ_W-1:0]   pending_q, pending_d;
  logic [IRQ_W-1:0]   overflow_q, overflow_d;
  logic               valid_q, valid_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [NUM_W-1:0]   last_q, last_d;
  logic [IRQ_W-1:0]   irq_event;
  logic [IRQ_W-1:0]   eligible;
  logic [IRQ_W-1:0]   ack_clr;
  logic [NUM_W-1:0]   idx;
  logic [NUM_W-1:0]   win;
  logic               found;

`ifdef UTIM64_IRQ_ARBITER_SYNC_EN
  logic [IRQ_W-1:0]   sync1_q, sync2_q;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= iTIMER_IRQ;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = iTIMER_IRQ;
`endif

  assign irq_event = irq_s & ~irq_d_q;
  assign eligible  = pending_q & ~mask_q;

  // An event coinciding with the ACK of its own line re-arms pending without counting as overflow.
  always_comb begin
    mask_d     = iMASK_WRITE ? iMASK_DATA : mask_q;
    pending_d  = (pending_q & ~ack_clr) | irq_event;
    overflow_d = (overflow_q & ~iOVF_CLEAR) | (irq_event & pending_q & ~ack_clr);
  end

  // FSM next-state and round-robin winner search starting after last grant.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    num_d   = num_q;
    last_d  = last_q;
    ack_clr = '0;
    idx     = '0;
    win     = '0;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = NUM_W'(last_q + NUM_W'(i + 1));
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    case (state_q)
      IDLE: begin
        if (found) begin
          num_d   = win;
          valid_d = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (iIRQ_ACK) begin
          ack_clr[num_q] = 1'b1;
          last_d         = num_q;
          valid_d        = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q    <= IDLE;
      irq_d_q    <= '0;
      mask_q     <= '1;
      pending_q  <= '0;
      overflow_q <= '0;
      valid_q    <= 1'b0;
      num_q      <= '0;
      last_q     <= NUM_W'(3);
    end else begin
      state_q    <= state_d;
      irq_d_q    <= irq_s;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      num_q      <= num_d;
      last_q     <= last_d;
    end
  end

  assign oMASK      = mask_q;
  assign oPENDING   = pending_q;
  assign oOVERFLOW  = overflow_q;
  assign oIRQ_VALID = valid_q;
  assign oIRQ_NUM   = num_q;

endmodule

// File: doc/utim64_irq_arbiter.md
# utim64_irq_arbiter

Interrupt arbiter directly downstream of the utim64 user timer. It captures the four comparator interrupt lines (`oIRQ_IRQ[3:0]`) as pending events and applies a per-line mask. It selects one unmasked pending line with round-robin priority and presents it to the CPU interrupt port through a valid/ack handshake. Per-line overflow is reported when an event arrives on a line that is already pending.

## Interface
Parameters: none.

Ports:
- `iCLOCK`  in  1  system clock; one clock; all state on rising edge
- `inRESET`  in  1  reset; asynchronous, active-low
- `iTIMER_IRQ`  in  4  from utim64 `oIRQ_IRQ`; bit n = comparator n
- `iMASK_WRITE`  in  1  load mask register this cycle
- `iMASK_DATA`  in  4  new mask; 1 = line masked
- `iOVF_CLEAR`  in  4  per-bit clear of overflow flags (pulse)
- `oMASK`  out  4  current mask
- `oPENDING`  out  4  pending flags
- `oOVERFLOW`  out  4  sticky overflow flags
- `oIRQ_VALID`  out  1  interrupt request to CPU
- `oIRQ_NUM`  out  2  line being requested; valid while `oIRQ_VALID`
- `iIRQ_ACK`  in  1  CPU accepts current request

## Operation
- Input stage: `iTIMER_IRQ` passes through the optional synchronizer (see Configuration) to produce `irq_s`. A 4-bit history register `irq_d` holds the previous `irq_s`. An event on line n is `irq_s[n] & !irq_d[n]` (rising edge only; a held level is a single event).
- Pending: an event sets `pending[n]`. Pending is set regardless of the mask; a masked line stays pending and becomes eligible when unmasked.
- Overflow: an event on line n while `pending[n]` is already 1 sets `overflow[n]`. `overflow[n]` is cleared by `iOVF_CLEAR[n]`. When set and clear hit the same bit in the same cycle, set wins.
- Eligible lines are `pending & ~mask`.
- The FSM has two states.
  - IDLE: if any line is eligible, register the winner into `oIRQ_NUM`, assert `oIRQ_VALID`, and move to REQ. Otherwise stay in IDLE.
  - REQ: hold `oIRQ_VALID=1` and keep `oIRQ_NUM` stable. On `iIRQ_ACK`, clear `pending[oIRQ_NUM]`, set `last = oIRQ_NUM`, deassert `oIRQ_VALID`, and return to IDLE. `iIRQ_ACK` in IDLE is ignored.
- Round-robin: the search starts at `(last+1) mod 4` and increments with wrap; the first eligible index wins. `last` resets to 3, so line 0 has first priority after reset.
- A mask write in REQ does not withdraw the outstanding request. The new mask applies from the next IDLE arbitration.
- If an event on line `oIRQ_NUM` occurs in the same cycle as the ACK, set wins: pending stays 1 and overflow is not set.
- Reset mid-operation forces IDLE and all outputs to their reset values. Any request in flight is lost.

## Timing
- Reset values: `oMASK=4'hF` (all masked), `oPENDING=0`, `oOVERFLOW=0`, `oIRQ_VALID=0`, `oIRQ_NUM=0`. Internally, `irq_d=0`, sync flops are 0, and `last=3`.
- Event latency, with the synchronizer: `iTIMER_IRQ[n]` is high at clock edge k. `oPENDING[n]=1` after edge k+2. `oIRQ_VALID=1` after edge k+3, provided the line is unmasked and the FSM is in IDLE.
- Event latency, without the synchronizer: `oPENDING[n]=1` after edge k. `oIRQ_VALID=1` after edge k+1.
- ACK sampled at edge m: `oIRQ_VALID=0` and `pending` bit cleared after edge m. The earliest next `oIRQ_VALID` is after edge m+1, since there is one IDLE cycle between requests.
- A mask write takes effect on `oMASK` after the write edge. It gates arbitration from the following edge.
- The minimum input pulse is 1 `iCLOCK` cycle without the synchronizer. With the synchronizer, pulses from a slower timer clock domain must be at least 2 `iCLOCK` cycles wide.

## Configuration
- Macro `UTIM64_IRQ_ARBITER_SYNC_EN`.
- Defined: a two-flop synchronizer (reset to 0) on each `iTIMER_IRQ` bit. Required when `iTIMER_CLOCK` in utim64 differs from `iCLOCK`. It adds 2 cycles of event latency.
- Undefined: `irq_s = iTIMER_IRQ` directly, with no added latency. Only for builds where both clocks are the same.

## Test plan
- Reset, then write mask `4'h0`, then pulse `iTIMER_IRQ=4'b0100` for 1 cycle (sync off). Expect: `oPENDING=4'b0100` after 1 edge, then `oIRQ_VALID=1` with `oIRQ_NUM=2` the following edge. Holding `iIRQ_ACK=0` for 5 cycles keeps the output stable. ACK clears pending and valid.
- Mask `4'hF`, event on line 1. Expect: pending=`0010` and no `oIRQ_VALID`. Write mask `4'h0` and expect `oIRQ_VALID`, `oIRQ_NUM=1`.
- Mask 0, `iTIMER_IRQ=4'hF` in one cycle, ACK each request immediately. Expect grant order 0,1,2,3. Then re-raise lines 0 and 2. Expect order 0,2, because `last=3` wraps to start at 0.
- Event on line 3 twice before ACK. Expect: `oOVERFLOW=4'b1000` and a single request. `iOVF_CLEAR=4'b1000` clears it. Repeat with event and clear in the same cycle and expect overflow to stay 1.
- During REQ on line 0, assert ACK in the same cycle as a new line-0 edge. Expect: pending[0] stays 1, overflow[0]=0, and a second request for line 0 after one IDLE cycle.
- With the synchronizer on, assert `inRESET=0` asynchronously while in REQ. Expect all outputs at reset values immediately. After release, the synchronizer latency measures 3 edges from input to `oIRQ_VALID`.
